// File: rtl/trigger_monitor_pkg.sv
// Shared definitions for the trigger monitor: FSM state encoding, status flag
// bit positions for register packing, and the optional timestamp width.
package trigger_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } mon_state_e;

    // Bit positions of the sticky flags inside the status word
    localparam int FLAG_PERIOD  = 0;
    localparam int FLAG_TIMEOUT = 1;
    localparam int NUM_FLAGS    = 2;

    localparam int TSTAMP_WIDTH = 64;

endpackage

// File: rtl/trigger_monitor_if.sv
// Configuration/status bundle between the trigger monitor and its register bank.
// tstamp_out exists only when TRIGGER_MON_TIMESTAMP_EN is defined.
interface trigger_monitor_if
    import trigger_monitor_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
);
    logic                   run;
    logic                   trigger_in;
    logic [COUNT_WIDTH-1:0] expected_period;
    logic [COUNT_WIDTH-1:0] tolerance;
    logic [COUNT_WIDTH-1:0] timeout;
    logic                   err_clear;

    logic [COUNT_WIDTH-1:0] period_out;
    logic [COUNT_WIDTH-1:0] width_out;
    logic [COUNT_WIDTH-1:0] pulse_count;
    logic                   meas_valid;
    logic                   period_err;
    logic                   timeout_err;
`ifdef TRIGGER_MON_TIMESTAMP_EN
    logic [TSTAMP_WIDTH-1:0] tstamp_out;
`endif

    modport master (
        output run, trigger_in, expected_period, tolerance, timeout, err_clear,
`ifdef TRIGGER_MON_TIMESTAMP_EN
        input  tstamp_out,
`endif
        input  period_out, width_out, pulse_count, meas_valid, period_err, timeout_err
    );

    modport slave (
        input  run, trigger_in, expected_period, tolerance, timeout, err_clear,
`ifdef TRIGGER_MON_TIMESTAMP_EN
        output tstamp_out,
`endif
        output period_out, width_out, pulse_count, meas_valid, period_err, timeout_err
    );

endinterface

// File: rtl/trigger_monitor_sync_edge_detect.sv
// Synchronizes an asynchronous line through SYNC_STAGES flops (>=2) and flags
// rising/falling edges of the synchronized level one flop further down.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/trigger_monitor.sv
// Trigger input monitor: measures period/high width, counts pulses, flags period
// deviation and loss of trigger. TRIGGER_MON_TIMESTAMP_EN adds a 64-bit rise timestamp.
module trigger_monitor
    import trigger_monitor_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    trigger_monitor_if.slave mon
);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    mon_state_e state_q, state_d;

    logic trig_level, trig_rise, trig_fall;

    logic [COUNT_WIDTH-1:0] cnt_p, cnt_w, cnt_e, width_lat;
    logic [COUNT_WIDTH-1:0] period_q, width_q, count_q;
    logic                   strobe_q;
    logic [NUM_FLAGS-1:0]   flags_q, flag_set;

    logic                   in_meas, take_rise, meas_take, timeout_hit, leave_to_idle;
    logic [COUNT_WIDTH:0]   lo_ext, hi_ext;
    logic [COUNT_WIDTH-1:0] lo_bound, hi_bound;
    logic                   period_bad;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mon.trigger_in),
        .level (trig_level),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    // Tolerance window in one extra bit so underflow/overflow clamp instead of wrapping
    always_comb begin
        lo_ext     = {1'b0, mon.expected_period} - {1'b0, mon.tolerance};
        hi_ext     = {1'b0, mon.expected_period} + {1'b0, mon.tolerance};
        lo_bound   = lo_ext[COUNT_WIDTH] ? '0      : lo_ext[COUNT_WIDTH-1:0];
        hi_bound   = hi_ext[COUNT_WIDTH] ? CNT_MAX : hi_ext[COUNT_WIDTH-1:0];
        period_bad = (cnt_p < lo_bound) || (cnt_p > hi_bound);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // An edge in the same cycle as the timeout threshold wins over the timeout
    always_comb begin
        state_d     = state_q;
        take_rise   = 1'b0;
        meas_take   = 1'b0;
        timeout_hit = 1'b0;
        in_meas     = (state_q == ST_HIGH) || (state_q == ST_LOW);
        if (!mon.run) begin
            state_d = ST_IDLE;
        end else begin
            if (in_meas && (mon.timeout != '0) && (cnt_e >= mon.timeout) &&
                !trig_rise && !trig_fall)
                timeout_hit = 1'b1;
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM: begin
                    if (trig_rise) begin
                        state_d   = ST_HIGH;
                        take_rise = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (timeout_hit)    state_d = ST_ARM;
                    else if (trig_fall) state_d = ST_LOW;
                end
                ST_LOW: begin
                    if (timeout_hit) begin
                        state_d = ST_ARM;
                    end else if (trig_rise) begin
                        state_d   = ST_HIGH;
                        take_rise = 1'b1;
                        meas_take = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        leave_to_idle = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    always_comb begin
        flag_set               = '0;
        flag_set[FLAG_PERIOD]  = meas_take && period_bad;
        flag_set[FLAG_TIMEOUT] = timeout_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p     <= '0;
            cnt_w     <= '0;
            cnt_e     <= '0;
            width_lat <= '0;
            period_q  <= '0;
            width_q   <= '0;
            count_q   <= '0;
            strobe_q  <= 1'b0;
            flags_q   <= '0;
        end else begin
            if (take_rise)    cnt_p <= CNT_ONE;
            else if (in_meas) cnt_p <= sat_inc(cnt_p);

            if (take_rise)                                 cnt_w <= CNT_ONE;
            else if ((state_q == ST_HIGH) && trig_level)   cnt_w <= sat_inc(cnt_w);

            if (trig_rise || trig_fall) cnt_e <= CNT_ONE;
            else if (in_meas)           cnt_e <= sat_inc(cnt_e);

            if ((state_q == ST_HIGH) && (state_d == ST_LOW)) width_lat <= cnt_w;

            strobe_q <= meas_take;
            if (meas_take) begin
                period_q <= cnt_p;
                width_q  <= width_lat;
            end

            if (leave_to_idle)  count_q <= '0;
            else if (take_rise) count_q <= sat_inc(count_q);

            // A flag being set in the same cycle as err_clear stays set
            flags_q <= flag_set | (flags_q & ~{NUM_FLAGS{mon.err_clear}});
        end
    end

    assign mon.period_out  = period_q;
    assign mon.width_out   = width_q;
    assign mon.pulse_count = count_q;
    assign mon.meas_valid  = strobe_q;
    assign mon.period_err  = flags_q[FLAG_PERIOD];
    assign mon.timeout_err = flags_q[FLAG_TIMEOUT];

`ifdef TRIGGER_MON_TIMESTAMP_EN
    logic [TSTAMP_WIDTH-1:0] cycle_q, tstamp_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q  <= '0;
            tstamp_q <= '0;
        end else begin
            cycle_q <= cycle_q + TSTAMP_WIDTH'(1);
            if (take_rise) tstamp_q <= cycle_q;
        end
    end

    assign mon.tstamp_out = tstamp_q;
`endif

endmodule

// File: tb/tb_trigger_monitor.sv
// Directed bench for trigger_monitor: a pulse table for measurement/tolerance
// behaviour plus hand-written timeout, run-drop, reset and timestamp sequences.
module tb_trigger_monitor;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   n_strobe;

    trigger_monitor_if #(.COUNT_WIDTH(32)) mon ();

    trigger_monitor #(
        .COUNT_WIDTH (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (mon.meas_valid === 1'b1) n_strobe++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int tol;
        int clr;
        int hi;
        int lo;
        int strobe;
        int period;
        int width;
        int perr;
        int count;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Rise is registered on the third edge after the pin goes high
    task automatic pulse(input int hi, input int lo, output logic strobe_seen);
        mon.trigger_in = 1'b1;
        repeat (3) step();
        strobe_seen = mon.meas_valid;
        repeat (hi - 3) step();
        mon.trigger_in = 1'b0;
        repeat (lo) step();
    endtask

    logic s;
    int   snap;
    logic [63:0] t1, t2;

    initial begin
        n_cmp = 0; n_bad = 0; n_strobe = 0;
        reset = 1'b0;
        mon.run = 1'b0; mon.trigger_in = 1'b0; mon.err_clear = 1'b0;
        mon.expected_period = 32'd10; mon.tolerance = 32'd0; mon.timeout = 32'd0;

        //            tol clr hi lo strobe period width perr count
        vecs[0]  = '{0, 0, 3, 7, 0,  0, 0, 0,  1};
        vecs[1]  = '{0, 0, 3, 7, 1, 10, 3, 0,  2};
        vecs[2]  = '{0, 0, 3, 7, 1, 10, 3, 0,  3};
        vecs[3]  = '{0, 0, 3, 7, 1, 10, 3, 0,  4};
        vecs[4]  = '{0, 0, 3, 9, 1, 10, 3, 0,  5};
        vecs[5]  = '{1, 0, 3, 7, 1, 12, 3, 1,  6};
        vecs[6]  = '{1, 0, 3, 7, 1, 10, 3, 1,  7};
        vecs[7]  = '{1, 1, 4, 5, 1, 11, 3, 0,  8};
        vecs[8]  = '{1, 0, 3, 7, 1,  9, 4, 0,  9};
        vecs[9]  = '{1, 0, 3, 5, 1, 10, 3, 0, 10};
        vecs[10] = '{1, 0, 3, 7, 1,  8, 3, 1, 11};

        #2 reset = 1'b1;
        step(); step();
        check("reset period_out",  mon.period_out, 0);
        check("reset width_out",   mon.width_out, 0);
        check("reset pulse_count", mon.pulse_count, 0);
        check("reset meas_valid",  mon.meas_valid, 0);
        check("reset period_err",  mon.period_err, 0);
        check("reset timeout_err", mon.timeout_err, 0);
        reset = 1'b0;
        mon.run = 1'b1;
        step(); step();

        for (int i = 0; i < 11; i++) begin
            mon.tolerance = vecs[i].tol;
            if (vecs[i].clr != 0) begin
                mon.err_clear = 1'b1;
                step();
                mon.err_clear = 1'b0;
            end
            pulse(vecs[i].hi, vecs[i].lo, s);
            check($sformatf("row%0d strobe", i), s, vecs[i].strobe);
            if (vecs[i].strobe != 0) begin
                check($sformatf("row%0d period_out", i), mon.period_out, vecs[i].period);
                check($sformatf("row%0d width_out", i), mon.width_out, vecs[i].width);
            end
            check($sformatf("row%0d period_err", i), mon.period_err, vecs[i].perr);
            check($sformatf("row%0d pulse_count", i), mon.pulse_count, vecs[i].count);
        end
        check("table strobes", n_strobe, 10);
        check("table timeout_err", mon.timeout_err, 0);

        // Timeout after the trigger stops
        mon.err_clear = 1'b1; mon.timeout = 32'd50;
        step();
        mon.err_clear = 1'b0;
        check("clear period_err", mon.period_err, 0);
        pulse(3, 7, s);
        pulse(3, 7, s);
        pulse(3, 0, s);
        repeat (52) step();
        check("timeout early", mon.timeout_err, 0);
        step();
        check("timeout fired", mon.timeout_err, 1);
        repeat (10) step();
        pulse(3, 7, s);
        check("post-timeout first rise strobe", s, 0);
        pulse(3, 7, s);
        check("post-timeout second rise strobe", s, 1);
        check("post-timeout period_out", mon.period_out, 10);
        check("post-timeout pulse_count", mon.pulse_count, 16);

        // run drops while HIGH
        mon.trigger_in = 1'b1;
        repeat (4) step();
        mon.run = 1'b0;
        snap = n_strobe;
        step();
        mon.trigger_in = 1'b0;
        repeat (5) step();
        check("run-low no strobe", n_strobe, snap);
        check("run-low period hold", mon.period_out, 10);
        check("run-low width hold", mon.width_out, 3);
        check("run-low timeout_err hold", mon.timeout_err, 1);
        mon.run = 1'b1;
        repeat (3) step();
        check("rerun pulse_count", mon.pulse_count, 0);
        check("rerun period hold", mon.period_out, 10);
        pulse(3, 7, s);
        check("rerun first strobe", s, 0);
        check("rerun count", mon.pulse_count, 1);

        // Async reset in LOW
        pulse(3, 5, s);
        check("pre-reset strobe", s, 1);
        #3 reset = 1'b1;
        #1;
        check("async period_out",  mon.period_out, 0);
        check("async width_out",   mon.width_out, 0);
        check("async pulse_count", mon.pulse_count, 0);
        check("async meas_valid",  mon.meas_valid, 0);
        check("async timeout_err", mon.timeout_err, 0);
        step();
        reset = 1'b0;
        mon.timeout = 32'd0;
        mon.tolerance = 32'd0;
        step(); step();

        // err_clear coincides with a period error
        pulse(3, 7, s);
        pulse(3, 9, s);
        check("pre-collision strobe", s, 1);
        mon.trigger_in = 1'b1;
        step(); step();
        mon.err_clear = 1'b1;
        step();
        mon.err_clear = 1'b0;
        check("collision strobe", mon.meas_valid, 1);
        check("collision period_out", mon.period_out, 12);
        check("collision period_err", mon.period_err, 1);
        step();
        mon.trigger_in = 1'b0;
        repeat (7) step();
        check("collision sticky", mon.period_err, 1);
        mon.err_clear = 1'b1;
        step();
        mon.err_clear = 1'b0;
        check("collision cleared", mon.period_err, 0);

`ifdef TRIGGER_MON_TIMESTAMP_EN
        pulse(3, 7, s);
        t1 = mon.tstamp_out;
        pulse(3, 7, s);
        t2 = mon.tstamp_out;
        check("tstamp delta", t2 - t1, 10);
`else
        t1 = 64'd0;
        t2 = 64'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
